// File: rtl/diffeq_solver_iter.sv
// -----------------------------------------------------------------------------
// diffeq_solver_iter
//
// Self-sequencing Euler solver for y'' + 3*x*y' + 3*y = 0:
//   while (x < a) { x1 = x + dx; u1 = u - 3*x*u*dx - 3*y*dx; y1 = y + u*dx; }
// One loop iteration takes four cycles (C1..C4) built from two shared
// multipliers and shared add/subtract units. All operands load in parallel
// when start is accepted in IDLE.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; aborts any solve without a done
//   start       begin a solve (sampled only in IDLE)
//   x_in        initial x (signed, IN_WIDTH, sign-extended to WIDTH)
//   dx_in       step dx
//   u_in        initial u = y'
//   y_in        initial y
//   a_in        loop bound a
//   busy        high while the controller is outside IDLE
//   done        one-cycle pulse when x_out/u_out/y_out are valid
//   x_out       final x
//   u_out       final u
//   y_out       final y
//   iter_count  loop iterations executed in this solve
//   overflow    sticky: any signed overflow seen during this solve
//   timeout     solve stopped by MAX_ITER while x < a still held
// -----------------------------------------------------------------------------
module diffeq_solver_iter #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 8,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] x_in,
  input  logic [IN_WIDTH-1:0] dx_in,
  input  logic [IN_WIDTH-1:0] u_in,
  input  logic [IN_WIDTH-1:0] y_in,
  input  logic [IN_WIDTH-1:0] a_in,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    x_out,
  output logic [WIDTH-1:0]    u_out,
  output logic [WIDTH-1:0]    y_out,
  output logic [ITER_W-1:0]   iter_count,
  output logic                overflow,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_C1   = 3'd1,
    S_C2   = 3'd2,
    S_C3   = 3'd3,
    S_C4   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic signed [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] THREE      = WIDTH'(32'sd3);
  localparam logic [ITER_W-1:0]       ITER_ZERO  = {ITER_W{1'b0}};
  localparam logic [ITER_W-1:0]       ITER_ONE   = ITER_W'(32'd1);
  localparam logic [ITER_W-1:0]       MAX_ITER_C = ITER_W'(MAX_ITER);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Sign-extend one input operand to the datapath width.
  function automatic logic signed [WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] v);
    sext = WIDTH'(v);
  endfunction

  // Full-precision signed product at 2*WIDTH.
  function automatic logic signed [2*WIDTH-1:0] mul_full(input logic signed [WIDTH-1:0] a,
                                                          input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ae;
    logic signed [2*WIDTH-1:0] be;
    ae       = (2*WIDTH)'(a);
    be       = (2*WIDTH)'(b);
    mul_full = ae * be;
  endfunction

  // Truncation to WIDTH is lossless only when the top WIDTH+1 bits all match
  // the sign of the kept part.
  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p);
    logic [WIDTH:0] top;
    top     = p[2*WIDTH-1:WIDTH-1];
    mul_ovf = (top != {(WIDTH+1){1'b0}}) && (top != {(WIDTH+1){1'b1}});
  endfunction

  // Signed overflow of a wrapped add (sub=0) or subtract (sub=1).
  function automatic logic addsub_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] r,
                                      input logic                    sub);
    logic same_sign;
    same_sign  = (a[WIDTH-1] == b[WIDTH-1]);
    addsub_ovf = (sub ? !same_sign : same_sign) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                   state_q;
  logic signed [WIDTH-1:0]  x_q, dx_q, u_q, y_q, a_q;
  logic signed [WIDTH-1:0]  t1_q, t2_q, t3_q, t4_q, t5_q, t6_q, t7_q;
  logic [ITER_W-1:0]        cnt_q;
  logic                     ovf_q, tmo_q, busy_q, done_q;
  logic [WIDTH-1:0]         xo_q, uo_q, yo_q;

  // Shared functional-unit operands and results
  logic signed [WIDTH-1:0]   m0_a_s, m0_b_s, m1_a_s, m1_b_s;
  logic signed [2*WIDTH-1:0] m0_p_s, m1_p_s;
  logic signed [WIDTH-1:0]   m0_r_s, m1_r_s;
  logic signed [WIDTH-1:0]   s0_a_s, s0_b_s, s1_a_s, s1_b_s;
  logic                      s0_sub_s, s1_sub_s;
  logic signed [WIDTH-1:0]   s0_r_s, s1_r_s;
  logic                      step_ovf_s;
  logic [ITER_W-1:0]         cnt_inc_s;
  logic signed [WIDTH-1:0]   x_ld_s, a_ld_s;

  // Operand steering for the shared multipliers and add/subtract units.
  always_comb begin
    m0_a_s   = ZERO;
    m0_b_s   = ZERO;
    m1_a_s   = ZERO;
    m1_b_s   = ZERO;
    s0_a_s   = ZERO;
    s0_b_s   = ZERO;
    s0_sub_s = 1'b0;
    s1_a_s   = ZERO;
    s1_b_s   = ZERO;
    s1_sub_s = 1'b0;
    case (state_q)
      S_C1: begin
        m0_a_s = dx_q;  m0_b_s = THREE;   // t1 = 3*dx
        m1_a_s = u_q;   m1_b_s = x_q;     // t2 = u*x
        s0_a_s = x_q;   s0_b_s = dx_q;    // t3 = x + dx
      end
      S_C2: begin
        m0_a_s = u_q;   m0_b_s = dx_q;    // t4 = u*dx
        m1_a_s = t1_q;  m1_b_s = t2_q;    // t5 = 3*dx*u*x
      end
      S_C3: begin
        m0_a_s = t1_q;  m0_b_s = y_q;     // t6 = 3*dx*y
        s0_a_s = u_q;   s0_b_s = t5_q;    // t7 = u - t5
        s0_sub_s = 1'b1;
      end
      S_C4: begin
        // Writeback cycle: both the u and y updates need an add/subtract.
        s0_a_s = t7_q;  s0_b_s = t6_q;    // u1 = t7 - t6
        s0_sub_s = 1'b1;
        s1_a_s = y_q;   s1_b_s = t4_q;    // y1 = y + t4
      end
      default: begin
        m0_a_s = ZERO;
      end
    endcase
  end

  // Functional-unit results, overflow flags and load-time compare values.
  // Idle units see zero operands and therefore never flag overflow.
  always_comb begin
    m0_p_s     = mul_full(m0_a_s, m0_b_s);
    m1_p_s     = mul_full(m1_a_s, m1_b_s);
    m0_r_s     = m0_p_s[WIDTH-1:0];
    m1_r_s     = m1_p_s[WIDTH-1:0];
    s0_r_s     = s0_sub_s ? (s0_a_s - s0_b_s) : (s0_a_s + s0_b_s);
    s1_r_s     = s1_sub_s ? (s1_a_s - s1_b_s) : (s1_a_s + s1_b_s);
    step_ovf_s = mul_ovf(m0_p_s) | mul_ovf(m1_p_s)
               | addsub_ovf(s0_a_s, s0_b_s, s0_r_s, s0_sub_s)
               | addsub_ovf(s1_a_s, s1_b_s, s1_r_s, s1_sub_s);
    cnt_inc_s  = cnt_q + ITER_ONE;
    x_ld_s     = sext(x_in);
    a_ld_s     = sext(a_in);
  end

  // Controller FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q  <= ZERO;  dx_q <= ZERO;  u_q  <= ZERO;  y_q  <= ZERO;  a_q <= ZERO;
      t1_q <= ZERO;  t2_q <= ZERO;  t3_q <= ZERO;  t4_q <= ZERO;
      t5_q <= ZERO;  t6_q <= ZERO;  t7_q <= ZERO;
      cnt_q  <= ITER_ZERO;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      xo_q   <= {WIDTH{1'b0}};
      uo_q   <= {WIDTH{1'b0}};
      yo_q   <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q    <= x_ld_s;
            dx_q   <= sext(dx_in);
            u_q    <= sext(u_in);
            y_q    <= sext(y_in);
            a_q    <= a_ld_s;
            cnt_q  <= ITER_ZERO;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b0;
            busy_q <= 1'b1;
            // Already past the bound: finish with zero iterations.
            state_q <= (x_ld_s >= a_ld_s) ? S_DONE : S_C1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_C1: begin
          t1_q    <= m0_r_s;
          t2_q    <= m1_r_s;
          t3_q    <= s0_r_s;
          ovf_q   <= ovf_q | step_ovf_s;
          state_q <= S_C2;
        end
        S_C2: begin
          t4_q    <= m0_r_s;
          t5_q    <= m1_r_s;
          ovf_q   <= ovf_q | step_ovf_s;
          state_q <= S_C3;
        end
        S_C3: begin
          t6_q    <= m0_r_s;
          t7_q    <= s0_r_s;
          ovf_q   <= ovf_q | step_ovf_s;
          state_q <= S_C4;
        end
        S_C4: begin
          u_q   <= s0_r_s;
          y_q   <= s1_r_s;
          x_q   <= t3_q;
          cnt_q <= cnt_inc_s;
          ovf_q <= ovf_q | step_ovf_s;
          // Exit tests use the new x (t3) and the incremented count; reaching
          // the bound takes precedence over the iteration limit.
          if (t3_q >= a_q) begin
            state_q <= S_DONE;
          end else if (cnt_inc_s == MAX_ITER_C) begin
            tmo_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_C1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          xo_q    <= x_q;
          uo_q    <= u_q;
          yo_q    <= y_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign x_out      = xo_q;
  assign u_out      = uo_q;
  assign y_out      = yo_q;
  assign iter_count = cnt_q;
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_diffeq_solver_iter.sv
// -----------------------------------------------------------------------------
// Testbench for diffeq_solver_iter. Three instances:
//   sel 0: default parameters (WIDTH=16, MAX_ITER=255)
//   sel 1: MAX_ITER=4 for the iteration-limit case
//   sel 2: WIDTH=8 for the narrow-datapath overflow case
// Operand inputs are shared; each instance has its own start.
// -----------------------------------------------------------------------------
module tb_diffeq_solver_iter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_r;
  int         sel;
  logic [7:0] x_i, dx_i, u_i, y_i, a_i;

  logic        start_a, start_t, start_n;
  logic        busy_a, done_a, ovf_a, tmo_a;
  logic [15:0] xo_a, uo_a, yo_a;
  logic [7:0]  it_a;
  logic        busy_t, done_t, ovf_t, tmo_t;
  logic [15:0] xo_t, uo_t, yo_t;
  logic [2:0]  it_t;
  logic        busy_n, done_n, ovf_n, tmo_n;
  logic [7:0]  xo_n, uo_n, yo_n;
  logic [7:0]  it_n;

  logic        obusy, odone, oovf, otmo;
  logic [15:0] ox, ou, oy;
  logic [7:0]  oit;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign start_a = start_r && (sel == 0);
  assign start_t = start_r && (sel == 1);
  assign start_n = start_r && (sel == 2);

  diffeq_solver_iter #(.WIDTH(16), .IN_WIDTH(8), .MAX_ITER(255), .ITER_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .x_in(x_i), .dx_in(dx_i), .u_in(u_i), .y_in(y_i), .a_in(a_i),
    .busy(busy_a), .done(done_a), .x_out(xo_a), .u_out(uo_a), .y_out(yo_a),
    .iter_count(it_a), .overflow(ovf_a), .timeout(tmo_a));

  diffeq_solver_iter #(.WIDTH(16), .IN_WIDTH(8), .MAX_ITER(4), .ITER_W(3)) dut_t (
    .clk(clk), .reset(reset), .start(start_t),
    .x_in(x_i), .dx_in(dx_i), .u_in(u_i), .y_in(y_i), .a_in(a_i),
    .busy(busy_t), .done(done_t), .x_out(xo_t), .u_out(uo_t), .y_out(yo_t),
    .iter_count(it_t), .overflow(ovf_t), .timeout(tmo_t));

  diffeq_solver_iter #(.WIDTH(8), .IN_WIDTH(8), .MAX_ITER(255), .ITER_W(8)) dut_n (
    .clk(clk), .reset(reset), .start(start_n),
    .x_in(x_i), .dx_in(dx_i), .u_in(u_i), .y_in(y_i), .a_in(a_i),
    .busy(busy_n), .done(done_n), .x_out(xo_n), .u_out(uo_n), .y_out(yo_n),
    .iter_count(it_n), .overflow(ovf_n), .timeout(tmo_n));

  // Route the selected instance onto one set of observation signals.
  always_comb begin
    case (sel)
      0: begin
        obusy = busy_a; odone = done_a; oovf = ovf_a; otmo = tmo_a;
        ox = xo_a; ou = uo_a; oy = yo_a; oit = it_a;
      end
      1: begin
        obusy = busy_t; odone = done_t; oovf = ovf_t; otmo = tmo_t;
        ox = xo_t; ou = uo_t; oy = yo_t; oit = {5'd0, it_t};
      end
      default: begin
        obusy = busy_n; odone = done_n; oovf = ovf_n; otmo = tmo_n;
        ox = {8'h00, xo_n}; ou = {8'h00, uo_n}; oy = {8'h00, yo_n}; oit = it_n;
      end
    endcase
  end

  typedef struct {
    int          sel;
    logic [7:0]  x, dx, u, y, a;
    logic [15:0] ex, eu, ey;
    logic [7:0]  eit;
    logic        eovf, etmo;
    int          elat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s.%s: got %0h, expected %0h", tag, what, act, exp);
    else
      n_pass++;
  endtask

  task automatic set_inputs(input vec_t v);
    x_i = v.x; dx_i = v.dx; u_i = v.u; y_i = v.y; a_i = v.a;
  endtask

  // Check every result port against a vector's expected values.
  task automatic chk_results(input string tag, input vec_t v);
    chk(tag, "x_out",    {16'h0, ox}, {16'h0, v.ex});
    chk(tag, "u_out",    {16'h0, ou}, {16'h0, v.eu});
    chk(tag, "y_out",    {16'h0, oy}, {16'h0, v.ey});
    chk(tag, "iter",     {24'h0, oit}, {24'h0, v.eit});
    chk(tag, "overflow", {31'h0, oovf}, {31'h0, v.eovf});
    chk(tag, "timeout",  {31'h0, otmo}, {31'h0, v.etmo});
  endtask

  // Start one solve, measure done latency, check results and the pulse width.
  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    lat = -1;
    sel = v.sel;
    set_inputs(v);
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    x_i = 8'h55; dx_i = 8'hAA; u_i = 8'h33; y_i = 8'hCC; a_i = 8'h0F;
    for (int k = 1; k <= 40; k++) begin
      if (lat < 0) begin
        @(posedge clk); #1;
        if (odone) lat = k;
      end
    end
    chk(tag, "latency", lat, v.elat);
    chk(tag, "busy_at_done", {31'h0, obusy}, 32'd0);
    chk_results(tag, v);
    @(posedge clk); #1;
    chk(tag, "done_one_cycle", {31'h0, odone}, 32'd0);
  endtask

  initial begin
    int ndone;
    int first_k;
    int second_k;

    //          sel  x      dx     u      y      a      x_out     u_out     y_out     it    ovf   tmo   lat
    vt[0] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 16'h0000, 16'h0000, 16'h0000, 8'd4, 1'b0, 1'b1, 17};
    vt[1] = '{2, 8'h00, 8'h64, 8'h64, 8'h00, 8'h01, 16'h0064, 16'h0064, 16'h0010, 8'd1, 1'b1, 1'b0, 5};
    vt[2] = '{0, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 16'h0002, 16'hFFFE, 16'h0000, 8'd2, 1'b0, 1'b0, 9};
    vt[3] = '{0, 8'h05, 8'h01, 8'h01, 8'h01, 8'h03, 16'h0005, 16'h0001, 16'h0001, 8'd0, 1'b0, 1'b0, 1};
    vt[4] = '{0, 8'hFD, 8'h02, 8'hFF, 8'h04, 8'hFD, 16'hFFFD, 16'hFFFF, 16'h0004, 8'd0, 1'b0, 1'b0, 1};
    vt[5] = '{0, 8'h00, 8'h02, 8'h01, 8'h00, 8'h01, 16'h0002, 16'h0001, 16'h0002, 8'd1, 1'b0, 1'b0, 5};
    vt[6] = '{0, 8'hFF, 8'h01, 8'h02, 8'h01, 8'h00, 16'h0000, 16'h0005, 16'h0003, 8'd1, 1'b0, 1'b0, 5};
    vt[7] = '{0, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h01, 16'h007F, 16'h437C, 16'h3F80, 8'd1, 1'b1, 1'b0, 5};

    sel = 0; start_r = 1'b0; reset = 1'b1;
    x_i = 8'h00; dx_i = 8'h00; u_i = 8'h00; y_i = 8'h00; a_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state of the default instance.
    chk("reset", "busy",     {31'h0, busy_a}, 32'd0);
    chk("reset", "done",     {31'h0, done_a}, 32'd0);
    chk("reset", "x_out",    {16'h0, xo_a}, 32'd0);
    chk("reset", "u_out",    {16'h0, uo_a}, 32'd0);
    chk("reset", "y_out",    {16'h0, yo_a}, 32'd0);
    chk("reset", "iter",     {24'h0, it_a}, 32'd0);
    chk("reset", "overflow", {31'h0, ovf_a}, 32'd0);
    chk("reset", "timeout",  {31'h0, tmo_a}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset during C3 of the two-iteration solve: no done, everything cleared.
    sel = 0;
    set_inputs(vt[2]);
    start_r = 1'b1;
    @(posedge clk); #1;          // C1
    start_r = 1'b0;
    @(posedge clk); #1;          // C2
    @(posedge clk); #1;          // C3
    chk("midreset", "busy_before", {31'h0, busy_a}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset", "busy",     {31'h0, busy_a}, 32'd0);
    chk("midreset", "done",     {31'h0, done_a}, 32'd0);
    chk("midreset", "x_out",    {16'h0, xo_a}, 32'd0);
    chk("midreset", "u_out",    {16'h0, uo_a}, 32'd0);
    chk("midreset", "y_out",    {16'h0, yo_a}, 32'd0);
    chk("midreset", "iter",     {24'h0, it_a}, 32'd0);
    chk("midreset", "overflow", {31'h0, ovf_a}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    chk("midreset", "no_done", ndone, 32'd0);
    run_vec(vt[2], "after_reset");

    // Start held high across two solves; inputs scrambled except at the
    // sampling edges, so both solves must reproduce the two-iteration result.
    sel = 0;
    set_inputs(vt[2]);
    start_r = 1'b1;
    ndone = 0; first_k = -1; second_k = -1;
    @(posedge clk); #1;          // first sampling edge
    x_i = 8'h80; dx_i = 8'h7F; u_i = 8'h40; y_i = 8'hC0; a_i = 8'h7F;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 9) set_inputs(vt[2]);   // sampled at the edge ending this cycle
      if (k == 10) begin
        x_i = 8'h11; dx_i = 8'h22; u_i = 8'h33; y_i = 8'h44; a_i = 8'h55;
      end
      if (done_a) begin
        ndone++;
        if (ndone == 1) begin
          first_k = k;
          chk_results("held1", vt[2]);
        end else if (ndone == 2) begin
          second_k = k;
          start_r = 1'b0;
          chk_results("held2", vt[2]);
        end
      end
    end
    start_r = 1'b0;
    chk("held", "first_done",  first_k, 32'd9);
    chk("held", "second_done", second_k, 32'd19);
    chk("held", "done_count",  ndone, 32'd2);
    chk("held", "busy_end",    {31'h0, busy_a}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
